pip_hazard_ctrl: RTL and testbench
==================================

# pip_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. It produces the per-stage write enables and bubble/flush selects consumed by the pipeline register bank (FET/DEC, DEC/EXE, EXE/MEM, MEM/WB) and the PC register. It resolves data-memory wait stalls, load-use hazards, taken-branch flushes and instruction-fetch bubbles. It also tracks memory-wait timeouts and keeps saturating performance counters.

## Interface
- MEM_TIMEOUT, 256: consecutive data-memory stall cycles before the core halts (≥2)
- CNT_W, 32: width of performance counters
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high)
- dec_rs1, dec_rs2  in  5 each  source registers of instruction in DEC
- dec_rs1_used, dec_rs2_used  in  1 each  source actually read
- exe_rd  in  5  destination of instruction in EXE
- exe_mem_read  in  1  instruction in EXE is a load
- exe_branch_taken  in  1  EXE resolved a taken branch/jump this cycle
- imem_ready  in  1  fetch data valid this cycle
- mem_req  in  1  MEM stage holds a load/store access
- dmem_ack  in  1  data memory completes the access this cycle
- pc_write_en, fet_dec_write_en, dec_exe_write_en, exe_mem_write_en, mem_wb_write_en  out  1 each  register update enables
- fet_dec_flush, dec_exe_flush, mem_wb_bubble  out  1 each  selects all-zero bubble as register input
- mem_timeout_err  out  1  sticky, memory never acknowledged
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters

## Operation
- load_use = exe_mem_read && exe_rd != 0 && ((dec_rs1_used && dec_rs1 == exe_rd) || (dec_rs2_used && dec_rs2 == exe_rd)).
- mem_stall = mem_req && !dmem_ack.
- States: RUN, MEM_WAIT, HALT. Enables are Mealy outputs of state plus current inputs.
- RUN/MEM_WAIT priority, highest first:
  - mem_stall: pc, fet_dec, dec_exe, exe_mem enables = 0; mem_wb_write_en = 1 with mem_wb_bubble = 1. Branch and load-use are ignored.
  - exe_branch_taken: all enables = 1; fet_dec_flush = dec_exe_flush = 1. flush_cnt += 1.
  - load_use: pc = fet_dec = 0; dec_exe = 1 with dec_exe_flush = 1; exe_mem = mem_wb = 1.
  - !imem_ready: pc = 0; fet_dec = 1 with fet_dec_flush = 1; others = 1.
  - else: all enables = 1, no flush/bubble.
- wait_cnt (internal, ≥ log2(MEM_TIMEOUT) bits):
  - Increments on each mem_stall cycle.
  - Clears on any cycle without mem_stall.
- Transitions:
  - RUN→MEM_WAIT on mem_stall.
  - MEM_WAIT→RUN when !mem_stall.
  - RUN/MEM_WAIT→HALT on a mem_stall cycle with wait_cnt == MEM_TIMEOUT-1.
  - HALT is left only by reset.
- HALT: all enables, flushes and bubble = 0; mem_timeout_err = 1.
- stall_cnt increments every non-reset cycle with pc_write_en == 0, including HALT. Both counters saturate at 2^CNT_W-1.

## Timing
- Reset values: state RUN, wait_cnt 0, counters 0, mem_timeout_err 0.
- While rst is high, all enables, flushes and bubble are forced 0.
- Enables are combinational, valid in the same cycle as the hazard inputs. The pipeline registers capture at the next edge.
- Load-use costs exactly one bubble. The next cycle, the load is in MEM and the hazard clears.
- Branch costs 2 killed instructions, zero stall cycles.
- dmem_ack in the cycle wait_cnt == MEM_TIMEOUT-1 prevents HALT: ack wins, and the cycle is not a stall.
- mem_stall and exe_branch_taken together: the branch is held in EXE. The flush happens in the first non-stall cycle, and flush_cnt increments once only.
- Reset asserted mid-MEM_WAIT or in HALT returns to RUN asynchronously and clears the error.

## Test plan
- Load-use: exe_mem_read=1, exe_rd=5, dec_rs1=5, dec_rs1_used=1 → one cycle with pc/fet_dec en=0, dec_exe_flush=1; stall_cnt=1. Same with exe_rd=0 → no stall.
- Branch: exe_branch_taken=1 → fet_dec_flush=dec_exe_flush=1, all enables 1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, ack after 3 cycles → 3 cycles with mem_wb_bubble=1 and other enables 0; state back to RUN; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, no ack → HALT after 4 stall cycles, mem_timeout_err=1, all enables 0. Ack at stall cycle 4 instead → no HALT.
- Simultaneous: mem_stall together with exe_branch_taken for 2 cycles, then ack → no flush during stall; flushes in the ack cycle; flush_cnt=1.
- Reset mid-wait: assert rst in MEM_WAIT and in HALT → outputs 0 immediately; after release, state RUN, counters 0, error cleared.

Source files
------------

// File: rtl/pip_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32I pipeline: per-stage write
// enables, flush/bubble selects, memory-wait timeout and performance counters.
//
// state    | meaning
// RUN      | normal issue, no outstanding data-memory stall
// MEM_WAIT | data memory has not acknowledged; upstream stages frozen
// HALT     | memory wait exceeded MEM_TIMEOUT cycles; core frozen until reset
module pip_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_rs1_used,
    input  logic             dec_rs2_used,
    input  logic [4:0]       exe_rd,
    input  logic             exe_mem_read,
    input  logic             exe_branch_taken,
    input  logic             imem_ready,
    input  logic             mem_req,
    input  logic             dmem_ack,
    output logic             pc_write_en,
    output logic             fet_dec_write_en,
    output logic             dec_exe_write_en,
    output logic             exe_mem_write_en,
    output logic             mem_wb_write_en,
    output logic             fet_dec_flush,
    output logic             dec_exe_flush,
    output logic             mem_wb_bubble,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              mem_stall;
    logic              flush_evt;

    assign mem_stall = mem_req && !dmem_ack;
    assign load_use  = exe_mem_read && (exe_rd != 5'd0) &&
                       ((dec_rs1_used && (dec_rs1 == exe_rd)) ||
                        (dec_rs2_used && (dec_rs2 == exe_rd)));

    assign mem_timeout_err = (state == HALT);

    always_comb begin
        state_next       = state;
        pc_write_en      = 1'b0;
        fet_dec_write_en = 1'b0;
        dec_exe_write_en = 1'b0;
        exe_mem_write_en = 1'b0;
        mem_wb_write_en  = 1'b0;
        fet_dec_flush    = 1'b0;
        dec_exe_flush    = 1'b0;
        mem_wb_bubble    = 1'b0;
        flush_evt        = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    // Only WB drains; a taken branch waits in EXE until the ack.
                    mem_wb_write_en = 1'b1;
                    mem_wb_bubble   = 1'b1;
                    state_next      = (wait_cnt == WAIT_LAST) ? HALT : MEM_WAIT;
                end else begin
                    state_next       = RUN;
                    pc_write_en      = 1'b1;
                    fet_dec_write_en = 1'b1;
                    dec_exe_write_en = 1'b1;
                    exe_mem_write_en = 1'b1;
                    mem_wb_write_en  = 1'b1;
                    if (exe_branch_taken) begin
                        fet_dec_flush = 1'b1;
                        dec_exe_flush = 1'b1;
                        flush_evt     = 1'b1;
                    end else if (load_use) begin
                        pc_write_en      = 1'b0;
                        fet_dec_write_en = 1'b0;
                        dec_exe_flush    = 1'b1;
                    end else if (!imem_ready) begin
                        pc_write_en   = 1'b0;
                        fet_dec_flush = 1'b1;
                    end
                end
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
        if (rst) begin
            pc_write_en      = 1'b0;
            fet_dec_write_en = 1'b0;
            dec_exe_write_en = 1'b0;
            exe_mem_write_en = 1'b0;
            mem_wb_write_en  = 1'b0;
            fet_dec_flush    = 1'b0;
            dec_exe_flush    = 1'b0;
            mem_wb_bubble    = 1'b0;
            flush_evt        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (mem_stall && (state != HALT)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write_en && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// Scoreboard bench for pip_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, compared against a rule-level reference model.
module tb_pip_hazard_ctrl;

    localparam int MT   = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [4:0]    dec_rs1, dec_rs2, exe_rd;
    logic          dec_rs1_used, dec_rs2_used;
    logic          exe_mem_read, exe_branch_taken, imem_ready, mem_req, dmem_ack;
    logic          pc_write_en, fet_dec_write_en, dec_exe_write_en;
    logic          exe_mem_write_en, mem_wb_write_en;
    logic          fet_dec_flush, dec_exe_flush, mem_wb_bubble, mem_timeout_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pip_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .exe_rd(exe_rd), .exe_mem_read(exe_mem_read),
        .exe_branch_taken(exe_branch_taken), .imem_ready(imem_ready),
        .mem_req(mem_req), .dmem_ack(dmem_ack),
        .pc_write_en(pc_write_en), .fet_dec_write_en(fet_dec_write_en),
        .dec_exe_write_en(dec_exe_write_en), .exe_mem_write_en(exe_mem_write_en),
        .mem_wb_write_en(mem_wb_write_en), .fet_dec_flush(fet_dec_flush),
        .dec_exe_flush(dec_exe_flush), .mem_wb_bubble(mem_wb_bubble),
        .mem_timeout_err(mem_timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ctl;   // {pc, fet_dec, dec_exe, exe_mem, mem_wb, fd_flush, de_flush, bubble}
        logic       err;
        int         stall;
        int         flush;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: halted flag, length of the current memory-wait run, counters.
    bit m_halt;
    int m_run;
    int m_stall;
    int m_flush;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v == CMAX) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_halt  = 1'b0;
        m_run   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_step();
        exp_t e;
        bit   lu, ms;
        lu = exe_mem_read && exe_rd != 0 &&
             ((dec_rs1_used && dec_rs1 == exe_rd) || (dec_rs2_used && dec_rs2 == exe_rd));
        ms = mem_req && !dmem_ack;
        if (m_halt)                e.ctl = 8'b00000_000;
        else if (ms)               e.ctl = 8'b00001_001;
        else if (exe_branch_taken) e.ctl = 8'b11111_110;
        else if (lu)               e.ctl = 8'b00111_010;
        else if (!imem_ready)      e.ctl = 8'b01111_100;
        else                       e.ctl = 8'b11111_000;
        e.err   = m_halt;
        e.stall = m_stall;
        e.flush = m_flush;
        q.push_back(e);
        if (!e.ctl[7]) m_stall = sat_inc(m_stall);
        if (!m_halt && !ms && exe_branch_taken) m_flush = sat_inc(m_flush);
        if (!m_halt) begin
            if (ms) begin
                m_run++;
                if (m_run == MT) m_halt = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic br, input logic im,
                         input logic mreq, input logic ack);
        @(posedge clk);
        #1;
        rst              = 1'b0;
        dec_rs1          = rs1;
        dec_rs2          = rs2;
        dec_rs1_used     = u1;
        dec_rs2_used     = u2;
        exe_rd           = rd;
        exe_mem_read     = mr;
        exe_branch_taken = br;
        imem_ready       = im;
        mem_req          = mreq;
        dmem_ack         = ack;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    endtask

    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        e.ctl   = 8'h00;
        e.err   = 1'b0;
        e.stall = 0;
        e.flush = 0;
        q.push_back(e);
        model_reset();
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ctl", int'({pc_write_en, fet_dec_write_en, dec_exe_write_en, exe_mem_write_en,
                             mem_wb_write_en, fet_dec_flush, dec_exe_flush, mem_wb_bubble}),
                int'(e.ctl));
            chk("mem_timeout_err", int'(mem_timeout_err), int'(e.err));
            chk("stall_cnt", int'(stall_cnt), e.stall);
            chk("flush_cnt", int'(flush_cnt), e.flush);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {dec_rs1, dec_rs2, exe_rd} = '0;
        {dec_rs1_used, dec_rs2_used, exe_mem_read, exe_branch_taken, mem_req, dmem_ack} = '0;
        imem_ready = 1'b1;
        model_reset();
        #12;
        do_reset();

        // Load-use on rs1, then the same with exe_rd = 0 and a load-use on rs2.
        drive(5, 0, 1, 0, 5, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("load_use_stall_cnt", int'(stall_cnt), 1);
        drive(0, 0, 1, 0, 0, 1, 0, 1, 0, 0);
        drive(3, 7, 1, 1, 7, 1, 0, 1, 0, 0);
        drive(7, 7, 0, 0, 7, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Branch flush.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle(1);
        @(negedge clk);
        chk("branch_flush_cnt", int'(flush_cnt), 1);
        chk("branch_stall_cnt", int'(stall_cnt), 0);

        // Memory wait of 3 cycles, then ack.
        do_reset();
        stall(3);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle(1);
        @(negedge clk);
        chk("mem_wait_stall_cnt", int'(stall_cnt), 3);

        // Timeout into HALT, and ack on the last allowed cycle.
        do_reset();
        stall(MT);
        idle(3);
        @(negedge clk);
        chk("timeout_err", int'(mem_timeout_err), 1);
        do_reset();
        stall(MT - 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle(2);

        // Stall together with a taken branch, branch flushes in the ack cycle.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        idle(1);
        @(negedge clk);
        chk("simul_flush_cnt", int'(flush_cnt), 1);

        // Reset in MEM_WAIT and in HALT.
        stall(2);
        do_reset();
        idle(2);
        stall(MT + 2);
        do_reset();
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0 || (m_halt && $urandom_range(0, 7) == 0)) begin
                do_reset();
            end else begin
                drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 3)),
                      $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2,
                      $urandom_range(0, 9) < 8, $urandom_range(0, 19) < 7,
                      $urandom_range(0, 1) == 1);
            end
        end

        // Stall counter saturation while halted.
        do_reset();
        stall(MT);
        idle(CMAX + 20);
        @(negedge clk);
        chk("stall_cnt_saturated", int'(stall_cnt), CMAX);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
